dispatch_sequencer: RTL
=======================

// Module: dispatch_sequencer
// PURPOSE
//  Buffers fetched instruction words and sequences them, one micro-op per cycle, into dispatch.
//  Sits between fetch and dispatch. Applies ROB/RS back-pressure (in_stall) and drops state on flush.
//  Cracks LDP/STP into two micro-ops (idx 0, then idx 1). Stops issue permanently after HLT.
// PARAMETERS
//  INSNBITS_SIZE  32  instruction word width (`INSNBITS_SIZE)
//  QUEUE_DEPTH    4   instruction queue entries; power of two, >=2
// PORTS
//  in_clk             in   1              clock, posedge
//  in_rst             in   1              reset, asynchronous, active-high
//  in_flush           in   1              mispredict flush: empties queue, cancels a crack in progress
//  in_stall           in   1              downstream cannot accept a micro-op this cycle
//  in_fetch_insnbits  in   INSNBITS_SIZE  fetched word
//  in_fetch_done      in   1              fetched word valid (push request)
//  out_fetch_stall    out  1              queue full or halted; fetch must not push
//  out_insnbits       out  INSNBITS_SIZE  micro-op word to dispatch (registered)
//  out_done           out  1              one-cycle pulse per issued micro-op (registered)
//  out_uop_idx        out  1              0 = first/only half; 1 = second half of LDP/STP
//  out_halted         out  1              HLT has issued; sticky until reset
//  out_overflow       out  1              sticky: push arrived while out_fetch_stall was high
// BEHAVIOUR
//  Reset (async, in_rst=1): queue empty, state RUN. All outputs 0 except out_fetch_stall, which follows the reset state (0).
//  Predecode of the head word:
//   LDP : bits[31:22]==10'b1010100011
//   STP : bits[31:22]==10'b1010100100
//   HLT : bits[31:21]==11'b11010100010 && bits[4:0]==0
//  Push: at the edge where in_fetch_done && !out_fetch_stall && !in_flush, the word is written at tail.
//  Issue: at an edge where state!=HALTED, count>0, !in_stall and !in_flush:
//   out_insnbits <= head word; out_done <= 1.
//   No issue at that edge: out_done <= 0 and out_insnbits holds.
//  Latency: a word pushed at edge k issues at edge k+1 at the earliest. There is no fetch->out bypass.
//  FSM (seq_state_t):
//   RUN: head is LDP/STP -> issue idx 0, do not pop, go to CRACK.
//        head is HLT -> issue idx 0, pop, go to HALTED.
//        other head -> issue idx 0, pop, stay in RUN.
//   CRACK: issue the same head with idx 1, pop, go to RUN. If stalled, hold CRACK with no issue.
//   HALTED: no issue; pushes are ignored; out_fetch_stall=1. Only reset exits HALTED.
//  out_fetch_stall = (count==QUEUE_DEPTH) || state==HALTED. Combinational from registered state.
//  Push and pop at the same edge: count unchanged, both pointers advance, with wrap mod QUEUE_DEPTH.
//  Full: a push is possible only at an edge after a pop has freed an entry. A pop at the full edge alone does not admit a same-edge push.
//  Overflow: a push request while out_fetch_stall=1 (not HALTED) drops the word and sets out_overflow.
//  Flush has priority over push and issue:
//   count <= 0; pointers <= 0; CRACK -> RUN; out_done <= 0.
//   HALTED and out_overflow are unaffected.
//  Reset mid-crack or mid-stall discards everything immediately (async).
//  Count width: $clog2(QUEUE_DEPTH)+1; pointers: $clog2(QUEUE_DEPTH); no arithmetic overflow possible.
// STRUCTURE
//  Shared package (data_structures.sv):
//   seq_state_t {SEQ_RUN, SEQ_CRACK, SEQ_HALTED}
//   LDP/STP/HLT predecode mask/value constants, shared with decode
//  Sub-module insn_queue: circular buffer with push/pop/flush, head data, count, full/empty.
//   Parameterised by INSNBITS_SIZE and QUEUE_DEPTH; same async-reset rule.
//  Top: predecode + FSM + registered outputs.
// TESTING
//  1. Push ADD 0x91000420 at edge 0, in_stall=0
//     -> out_done=1 after edge 1, out_insnbits=0x91000420, uop_idx=0; pulse lasts exactly 1 cycle.
//  2. Push LDP 0xA8C10BE1, then NOP 0xD503201F
//     -> three pulses on consecutive cycles: LDP/idx0, LDP/idx1, NOP/idx0.
//  3. Push 5 words with in_stall=1 (depth 4)
//     -> out_fetch_stall=1 after the 4th push; 5th word dropped, out_overflow=1.
//     -> release stall: words 1-4 issue in order, one per cycle, and count returns to 0.
//  4. LDP issues idx0, then in_flush=1 with a push the same cycle
//     -> no idx1 issue; queue empty; pushed word discarded; state RUN; out_overflow unchanged.
//  5. Push HLT 0xD4400000, then ADD
//     -> HLT issues once, out_halted=1 and out_fetch_stall=1; ADD never issues; in_flush leaves out_halted=1.
//  6. Assert in_rst mid-crack, between clock edges
//     -> out_done, out_halted, out_overflow and count read 0 before the next edge.

Source files
------------

// File: rtl/dispatch_sequencer_pkg.sv
// Shared types and predecode constants for the dispatch sequencer and decode.
// Instruction classes are recognised by masked compares on the 32-bit word.
package dispatch_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'd0,
    SEQ_CRACK  = 2'd1,
    SEQ_HALTED = 2'd2
  } seq_state_t;

  localparam logic [31:0] LDP_MASK  = 32'hFFC0_0000;
  localparam logic [31:0] LDP_VALUE = 32'hA8C0_0000;
  localparam logic [31:0] STP_MASK  = 32'hFFC0_0000;
  localparam logic [31:0] STP_VALUE = 32'hA900_0000;
  localparam logic [31:0] HLT_MASK  = 32'hFFE0_001F;
  localparam logic [31:0] HLT_VALUE = 32'hD440_0000;

  // Load/store pair words are cracked into two micro-ops.
  function automatic logic is_pair(input logic [31:0] word);
    return ((word & LDP_MASK) == LDP_VALUE) || ((word & STP_MASK) == STP_VALUE);
  endfunction

  function automatic logic is_hlt(input logic [31:0] word);
    return (word & HLT_MASK) == HLT_VALUE;
  endfunction

endpackage

// File: rtl/dispatch_sequencer_insn_queue.sv
// Circular instruction buffer with push, pop and flush; exposes head word and occupancy.
// Callers guarantee no push when full and no pop when empty.
module dispatch_sequencer_insn_queue #(
  parameter int INSNBITS_SIZE = 32,
  parameter int QUEUE_DEPTH   = 4,
  localparam int PTR_W        = $clog2(QUEUE_DEPTH),
  localparam int CNT_W        = PTR_W + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [INSNBITS_SIZE-1:0] push_data_i,
  output logic [INSNBITS_SIZE-1:0] head_o,
  output logic [CNT_W-1:0]         count_o
);

  logic [INSNBITS_SIZE-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]         head_ptr_q;
  logic [PTR_W-1:0]         tail_ptr_q;
  logic [CNT_W-1:0]         count_q;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_ptr_q] <= push_data_i;
        tail_ptr_q        <= tail_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        head_ptr_q <= head_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[head_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dispatch_sequencer.sv
// Sequences queued instruction words into dispatch one micro-op per cycle,
// cracking LDP/STP into two halves and stopping for good after HLT.
module dispatch_sequencer
  import dispatch_sequencer_pkg::*;
#(
  parameter int INSNBITS_SIZE = 32,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_flush,
  input  logic                     in_stall,
  input  logic [INSNBITS_SIZE-1:0] in_fetch_insnbits,
  input  logic                     in_fetch_done,
  output logic                     out_fetch_stall,
  output logic [INSNBITS_SIZE-1:0] out_insnbits,
  output logic                     out_done,
  output logic                     out_uop_idx,
  output logic                     out_halted,
  output logic                     out_overflow
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  seq_state_t               state_q, state_d;
  logic [INSNBITS_SIZE-1:0] q_head_s;
  logic [CNT_W-1:0]         q_count_s;
  logic                     empty_s, full_s, halted_s;
  logic                     push_s, pop_s, issue_s, can_issue_s, uop_idx_d;
  logic [INSNBITS_SIZE-1:0] insn_q;
  logic                     done_q, uop_idx_q, overflow_q;

  assign empty_s         = (q_count_s == CNT_W'(0));
  assign full_s          = (q_count_s == CNT_W'(QUEUE_DEPTH));
  assign halted_s        = (state_q == SEQ_HALTED);
  assign out_fetch_stall = full_s || halted_s;
  assign push_s          = in_fetch_done && !out_fetch_stall && !in_flush;
  assign can_issue_s     = !halted_s && !empty_s && !in_stall && !in_flush;

  dispatch_sequencer_insn_queue #(
    .INSNBITS_SIZE (INSNBITS_SIZE),
    .QUEUE_DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (in_clk),
    .rst_i       (in_rst),
    .flush_i     (in_flush),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (in_fetch_insnbits),
    .head_o      (q_head_s),
    .count_o     (q_count_s)
  );

  // Next-state and issue decisions; a pair head stays queued until its second half issues.
  always_comb begin
    state_d   = state_q;
    issue_s   = 1'b0;
    pop_s     = 1'b0;
    uop_idx_d = 1'b0;
    case (state_q)
      SEQ_RUN: begin
        if (can_issue_s) begin
          issue_s = 1'b1;
          if (is_pair(q_head_s)) begin
            state_d = SEQ_CRACK;
          end else begin
            pop_s   = 1'b1;
            state_d = is_hlt(q_head_s) ? SEQ_HALTED : SEQ_RUN;
          end
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_CRACK: begin
        if (can_issue_s) begin
          issue_s   = 1'b1;
          pop_s     = 1'b1;
          uop_idx_d = 1'b1;
          state_d   = SEQ_RUN;
        end else begin
          state_d = SEQ_CRACK;
        end
      end
      SEQ_HALTED: state_d = SEQ_HALTED;
      default:    state_d = SEQ_RUN;
    endcase
    if (in_flush && !halted_s) begin
      state_d = SEQ_RUN;
    end else begin
      state_d = state_d;
    end
  end

  // State and registered dispatch outputs; overflow is sticky until reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= SEQ_RUN;
      insn_q     <= '0;
      done_q     <= 1'b0;
      uop_idx_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= issue_s;
      if (issue_s) begin
        insn_q    <= q_head_s;
        uop_idx_q <= uop_idx_d;
      end
      if (in_fetch_done && full_s && !halted_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_insnbits = insn_q;
  assign out_done     = done_q;
  assign out_uop_idx  = uop_idx_q;
  assign out_halted   = halted_s;
  assign out_overflow = overflow_q;

endmodule
